// File: rtl/permutation_driver.sv
// permutation_driver: buffers Count input slices, sequences a run on the permutation core, captures results.
// Optional: define PERM_DRV_OVERRUN_EN for the sticky overrun protocol-error flag.
module permutation_driver #(
    parameter int N     = 5,
    parameter int Count = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     loadValid,
    input  logic [N*N-1:0]           loadData,
    output logic                     loadReady,
    input  logic                     go,
    output logic                     busy,
    output logic                     done,
    input  logic [$clog2(Count)-1:0] rdAddr,
    output logic [N*N-1:0]           rdData,
    input  logic                     ready,
    output logic                     start,
    input  logic                     putInput,
    output logic [N*N-1:0]           matrixIn,
    input  logic                     outReady,
    input  logic [N*N-1:0]           matrixOut,
    output logic                     overrun
);
    localparam int AW = $clog2(Count);
    localparam int W  = N * N;
    localparam logic [AW:0] FULL = (AW + 1)'(Count);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        START,
        FEED,
        DONE
    } state_t;

    state_t        state_q;
    logic [AW:0]   load_cnt_q;
    logic [AW:0]   feed_cnt_q;
    logic [AW:0]   cap_cnt_q;
    logic [AW-1:0] feed_ptr_q;
    logic [AW-1:0] cap_ptr_q;
    logic          start_q;
    logic          busy_q;
    logic          done_q;
    logic          ovr_q;
    logic [W-1:0]  rd_data_q;

    logic [W-1:0]  in_buf  [Count];
    logic [W-1:0]  res_buf [Count];

    logic          in_feed;
    logic          load_en;
    logic          feed_ok;
    logic          cap_ok;
    logic          ovr_ev;
    logic [AW:0]   feed_cnt_d;

    always_comb begin
        in_feed    = (state_q == FEED);
        load_en    = loadValid & loadReady;
        feed_ok    = in_feed & putInput & (feed_cnt_q != FULL);
        feed_cnt_d = feed_cnt_q + {{AW{1'b0}}, feed_ok};
`ifdef PERM_DRV_OVERRUN_EN
        // a capture may not run ahead of the slices handed out so far
        cap_ok = in_feed & outReady & (cap_cnt_q < feed_cnt_d);
        ovr_ev = (in_feed & putInput & (feed_cnt_q == FULL))
               | (outReady & ~in_feed)
               | (in_feed & outReady & (cap_cnt_q >= feed_cnt_d));
`else
        cap_ok = in_feed & outReady;
        ovr_ev = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            load_cnt_q <= '0;
            feed_cnt_q <= '0;
            cap_cnt_q  <= '0;
            feed_ptr_q <= '0;
            cap_ptr_q  <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_data_q <= res_buf[rdAddr];
            if (ovr_ev) ovr_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (load_en) load_cnt_q <= load_cnt_q + 1'b1;
                    if (go && (load_cnt_q == FULL)) begin
                        state_q    <= WAIT_RDY;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        ovr_q      <= 1'b0;
                        feed_ptr_q <= '0;
                        cap_ptr_q  <= '0;
                        feed_cnt_q <= '0;
                        cap_cnt_q  <= '0;
                    end
                end
                WAIT_RDY: begin
                    if (ready) begin
                        state_q <= START;
                        start_q <= 1'b1;
                    end
                end
                START: begin
                    if (!ready) begin
                        state_q <= FEED;
                        start_q <= 1'b0;
                    end
                end
                FEED: begin
                    if (feed_ok) begin
                        feed_ptr_q <= feed_ptr_q + 1'b1;
                        feed_cnt_q <= feed_cnt_d;
                    end
                    if (cap_ok) begin
                        cap_ptr_q <= cap_ptr_q + 1'b1;
                        cap_cnt_q <= cap_cnt_q + 1'b1;
                        if (cap_cnt_q == FULL - 1'b1) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    load_cnt_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (load_en) in_buf[load_cnt_q[AW-1:0]] <= loadData;
        if (cap_ok)  res_buf[cap_ptr_q] <= matrixOut;
    end

    assign loadReady = (state_q == IDLE) & (load_cnt_q != FULL);
    assign matrixIn  = in_feed ? in_buf[feed_ptr_q] : '0;
    assign start     = start_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = ovr_q;
    assign rdData    = rd_data_q;

endmodule

// File: tb/tb_permutation_driver.sv
// tb_permutation_driver: scoreboard bench for permutation_driver with a small core model.
// Overrun expectations follow PERM_DRV_OVERRUN_EN.
module tb_permutation_driver;
    localparam int N   = 5;
    localparam int CNT = 64;
    localparam int W   = N * N;
    localparam int AW  = 6;
`ifdef PERM_DRV_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          loadValid = 1'b0;
    logic [W-1:0]  loadData = '0;
    logic          loadReady;
    logic          go = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] rdAddr = '0;
    logic [W-1:0]  rdData;
    logic          ready = 1'b0;
    logic          start;
    logic          putInput = 1'b0;
    logic [W-1:0]  matrixIn;
    logic          outReady = 1'b0;
    logic [W-1:0]  matrixOut = '0;
    logic          overrun;

    int n_chk  = 0;
    int n_fail = 0;
    logic [W-1:0] model [CNT];
    logic [W-1:0] sb [$];

    always #5 clk = ~clk;

    permutation_driver #(.N(N), .Count(CNT)) dut (
        .clk(clk), .rst(rst),
        .loadValid(loadValid), .loadData(loadData), .loadReady(loadReady),
        .go(go), .busy(busy), .done(done),
        .rdAddr(rdAddr), .rdData(rdData),
        .ready(ready), .start(start),
        .putInput(putInput), .matrixIn(matrixIn),
        .outReady(outReady), .matrixOut(matrixOut),
        .overrun(overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fill(input int kind);
        for (int i = 0; i < CNT; i++) begin
            case (kind)
                0:       model[i] = W'(i * 32'h3F1);
                1:       model[i] = W'($urandom);
                default: model[i] = ~W'(i * 3);
            endcase
        end
    endtask

    task automatic load_range(input int from, input int to);
        for (int i = from; i < to; i++) begin
            check("ld_rdy", loadReady, 1);
            loadValid = 1'b1;
            loadData  = model[i];
            tick();
        end
        loadValid = 1'b0;
    endtask

    task automatic idle_outs(input string tag);
        check({tag, "_start"}, start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ovr"}, overrun, 0);
        check({tag, "_min"}, matrixIn, 0);
        check({tag, "_lrdy"}, loadReady, 1);
    endtask

    task automatic go_and_start(input int hold);
        int n;
        ready = 1'b0;
        go = 1'b1;
        tick();
        go = 1'b0;
        check("go_busy", busy, 1);
        check("go_done", done, 0);
        check("go_ovr", overrun, 0);
        n = 0;
        for (int i = 0; i < hold; i++) begin
            if (start) n++;
            tick();
        end
        check("wait_start", n, 0);
        ready = 1'b1;
        tick();
        check("start_rise", start, 1);
        ready = 1'b0;
        tick();
        check("start_fall", start, 0);
        check("feed_busy", busy, 1);
    endtask

    task automatic feed_run(input int mode);
        int fed = 0;
        int caps = 0;
        int cyc = 0;
        bit seen = 0;
        bit p;
        bit dv [3] = '{0, 0, 0};
        logic [W-1:0] dd [3];
        while (!seen && cyc < 400) begin
            p = (fed < CNT);
            if (p) begin
                check("mat_in", matrixIn, model[fed]);
                sb.push_back(model[fed]);
            end
            if (mode == 1) begin
                outReady  = p;
                matrixOut = matrixIn;
            end else begin
                outReady  = dv[2];
                matrixOut = dd[2];
                dv[2] = dv[1]; dd[2] = dd[1];
                dv[1] = dv[0]; dd[1] = dd[0];
                dv[0] = p;     dd[0] = matrixIn;
            end
            putInput = p;
            if (p) fed++;
            if (outReady) caps++;
            tick();
            cyc++;
            putInput = 1'b0;
            outReady = 1'b0;
            if (done) seen = 1;
        end
        check("done_seen", seen, 1);
        check("done_caps", caps, CNT);
        check("done_fed", fed, CNT);
        check("done_busy", busy, 0);
    endtask

    task automatic post_done();
        tick();
        check("idle_lrdy", loadReady, 1);
        check("done_hold", done, 1);
    endtask

    task automatic readback();
        for (int i = 0; i < CNT; i++) begin
            rdAddr = AW'(i);
            tick();
            if (sb.size() == 0) check("sb_empty", 1, 0);
            else check("rd", rdData, sb.pop_front());
        end
        check("sb_left", sb.size(), 0);
    endtask

    task automatic overrun_run();
        for (int k = 0; k < CNT; k++) begin
            check("ov_in", matrixIn, model[k]);
            putInput = 1'b1;
            tick();
        end
        putInput = 1'b0;
        check("wrap_in", matrixIn, model[0]);
        check("ovr_pre", overrun, 0);
        putInput = 1'b1;
        tick();
        putInput = 1'b0;
        check("ovr_set", overrun, OVR_EXP);
        check("wrap_hold", matrixIn, model[0]);
        for (int k = 0; k < CNT; k++) begin
            outReady  = 1'b1;
            matrixOut = model[k] ^ 25'h0AAAAAA;
            sb.push_back(model[k] ^ 25'h0AAAAAA);
            tick();
        end
        outReady = 1'b0;
        check("ov_done", done, 1);
        check("ov_busy", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        #12;
        check("rst_rd", rdData, 0);
        idle_outs("rst");
        rst = 1'b1;
        @(negedge clk);

        fill(0);
        load_range(0, 10);
        rst = 1'b0;
        #1;
        check("mid_rd", rdData, 0);
        tick();
        rst = 1'b1;
        tick();
        idle_outs("mid");

        load_range(0, CNT - 1);
        ready = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (start || busy) n++;
            tick();
        end
        check("go63_idle", n, 0);
        ready = 1'b0;
        load_range(CNT - 1, CNT);
        check("full_lrdy", loadReady, 0);
        loadValid = 1'b1;
        loadData  = 25'h1FFFFFF;
        tick();
        loadValid = 1'b0;
        go_and_start(20);
        feed_run(0);
        post_done();
        readback();

        fill(1);
        load_range(0, CNT);
        go_and_start(2);
        feed_run(1);
        post_done();
        readback();

        fill(2);
        load_range(0, CNT);
        go_and_start(2);
        overrun_run();
        post_done();
        check("ovr_stay", overrun, OVR_EXP);
        readback();

        fill(1);
        load_range(0, CNT);
        go_and_start(3);
        feed_run(1);
        post_done();
        readback();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/permutation_driver.md
Name: permutation_driver

Overview:
- Host-side initiator for the slice-serial permutation core.
- Buffers Count input slices of N*N bits each, loaded from upstream.
- Issues start, then answers each putInput request with the next slice on matrixIn.
- Captures each matrixOut beat qualified by outReady into a result buffer that the system reads back by index. Sits between the system bus and the permutation core.

Parameters:
- N, 5, slice edge; slice width is N*N bits.
- Count, 64, slices per permutation run; must be a power of 2, at least 2.
- AW, $clog2(Count), index width (localparam).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low.
- loadValid  in  1  upstream slice valid.
- loadData  in  N*N  upstream slice.
- loadReady  out  1  input buffer accepts a slice (state IDLE and fewer than Count slices loaded).
- go  in  1  begin a run; honoured only in IDLE with a full buffer.
- busy  out  1  run in progress (states WAIT_RDY, START, FEED).
- done  out  1  all Count results captured; held until the next go or reset.
- rdAddr  in  AW  result buffer read index.
- rdData  out  N*N  result slice at rdAddr, registered, 1-cycle latency.
- ready  in  1  core idle and able to accept start.
- start  out  1  run request to the core.
- putInput  in  1  core requests the next input slice.
- matrixIn  out  N*N  slice presented to the core.
- outReady  in  1  matrixOut valid this cycle.
- matrixOut  in  N*N  result slice from the core.
- overrun  out  1  protocol error flag; see Optional Feature.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; loadCnt, feedPtr and capPtr cleared to 0.
  - start, busy, done, overrun = 0; matrixIn = 0; rdData = 0.
  - Buffer contents are not reset.
- Reset asserted mid-run aborts the run immediately. The core is not notified; the system resets both blocks together.
- Load, IDLE only:
  - On a cycle with loadValid & loadReady, write loadData at loadCnt and increment loadCnt.
  - loadReady drops once loadCnt == Count.
  - loadValid while loadReady is low is ignored, with no write.
- States:
  - IDLE: go & (loadCnt == Count) -> WAIT_RDY; clear done, feedPtr and capPtr. go is ignored otherwise.
  - WAIT_RDY: start = 0. ready -> START.
  - START: start = 1, held each cycle until ready is sampled low, then -> FEED with start = 0 in the next cycle. Matches the core dropping ready on acceptance.
  - FEED:
    - matrixIn = inBuf[feedPtr], combinational from the registered pointer.
    - Each rising edge with putInput = 1 consumes one slice: feedPtr increments, wrapping at Count.
    - feedCnt, of width AW+1, counts consumed slices.
    - Each rising edge with outReady = 1 writes matrixOut to resBuf[capPtr] and increments capPtr.
    - putInput and outReady in the same cycle: both actions occur independently.
    - When the capture count reaches Count -> DONE.
  - DONE: done = 1 and busy = 0. Next cycle -> IDLE with done held at 1 and loadCnt cleared to 0, ready for reload.
- Outputs are glitch-free:
  - start, busy and done are registered.
  - matrixIn changes only after the edge that consumed the previous slice.
- putInput after Count slices have been consumed: matrixIn shows the wrapped slice 0; feedPtr does not advance further.
- rdAddr is readable in any state. A read that collides with a same-cycle capture at the same index returns the old data.

Optional Feature:
- Macro: PERM_DRV_OVERRUN_EN.
- Defined:
  - overrun sets, and stays set until reset or the next accepted go, on any of:
    - putInput with feedCnt == Count;
    - outReady outside FEED;
    - capture count exceeding feedCnt.
  - The event that sets overrun is still not applied: no pointer change and no write.
- Undefined:
  - overrun is tied to 0.
  - Out-of-window outReady is silently dropped; extra putInput follows the base rule.

Test Plan:
- Reset mid-load: load 10 slices, pulse rst low -> loadCnt = 0, loadReady = 1, all outputs 0 one cycle after release.
- Full run with an identity-like core model (matrixOut = matrixIn delayed 3 cycles), slices i = i*25'h0003F1 for i = 0..63 -> done rises after capture 64; rdAddr = 17 returns 17*25'h0003F1 one cycle later.
- go with only 63 slices loaded -> stays IDLE, start never asserts. The 64th load followed by go -> start asserts once ready = 1.
- Core holds ready low for 20 cycles after go -> start stays 0 in WAIT_RDY. start rises the cycle after ready rises and falls once ready drops.
- putInput and outReady asserted in the same cycles throughout -> 64 slices fed and 64 captured, with no loss or duplication of indices.
- PERM_DRV_OVERRUN_EN: a 65th putInput pulse -> overrun = 1, feedPtr unchanged. Next go -> overrun = 0. Without the macro, overrun stays 0.
